// File: rtl/fod_spi_pkg.sv
// fod_spi_pkg: shared definitions for the FOD SPI target.
//   - FCW widths (WI integer bits, WF fraction bits)
//   - register address enum, per-address reset values, write masks
//   - receive FSM state enum
package fod_spi_pkg;

    localparam int WI   = 7;
    localparam int WF   = 16;
    localparam int WFCW = WI + WF;
    localparam int NREG = 13;

    typedef enum logic [4:0] {
        ADDR_FCW0   = 5'h00,
        ADDR_FCW1   = 5'h01,
        ADDR_FCW2   = 5'h02,
        ADDR_CTRL   = 5'h03,
        ADDR_KS     = 5'h04,
        ADDR_PHASE  = 5'h05,
        ADDR_MISC   = 5'h06,
        ADDR_KBC    = 5'h07,
        ADDR_KD     = 5'h08,
        ADDR_KDTCB  = 5'h09,
        ADDR_KDTCC  = 5'h0A,
        ADDR_KDTCD0 = 5'h0B,
        ADDR_KDTCD1 = 5'h0C
    } reg_addr_e;

    localparam logic [9:0] RST_FCW0   = 10'h28F;
    localparam logic [9:0] RST_FCW1   = 10'h210;
    localparam logic [9:0] RST_FCW2   = 10'h000;
    localparam logic [9:0] RST_CTRL   = 10'h309;
    localparam logic [9:0] RST_KS     = 10'h100;
    localparam logic [9:0] RST_PHASE  = 10'h000;
    localparam logic [9:0] RST_MISC   = 10'h178;
    localparam logic [9:0] RST_KBC    = 10'h3A0;
    localparam logic [9:0] RST_KD     = 10'h01D;
    localparam logic [9:0] RST_KDTCB  = 10'h2B6;
    localparam logic [9:0] RST_KDTCC  = 10'h15B;
    localparam logic [9:0] RST_KDTCD0 = 10'h064;
    localparam logic [9:0] RST_KDTCD1 = 10'h064;

    localparam logic [9:0] REG_RST [0:NREG-1] = '{
        RST_FCW0, RST_FCW1, RST_FCW2, RST_CTRL, RST_KS, RST_PHASE, RST_MISC,
        RST_KBC, RST_KD, RST_KDTCB, RST_KDTCC, RST_KDTCD0, RST_KDTCD1
    };

    // 8.26 in Q7.16: the committed word matches the staging reset values
    localparam logic [WFCW-1:0] RST_FCW = 23'h08428F;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FULL  = 2'd2
    } spi_state_e;

    // Implemented bits per address; unused bits are stored as 0 so they read 0.
    function automatic logic [9:0] wr_mask(input logic [4:0] addr);
        case (addr)
            ADDR_FCW2: wr_mask = 10'h007;
            ADDR_KD:   wr_mask = 10'h03F;
            default:   wr_mask = 10'h3FF;
        endcase
    endfunction

endpackage

// File: rtl/fod_spi_sync.sv
// fod_spi_sync: 2-flop synchronizer with registered edge pulses.
//   clk_i, rst_i : system clock, async active-high reset
//   d_i          : asynchronous input
//   q_o          : synchronized level
//   rise_o/fall_o: one-cycle pulses, asserted in the same cycle q_o changes
module fod_spi_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q;
    logic s2_q;
    logic rise_q;
    logic fall_q;

    // Two-stage synchronizer; edges are judged between the stages so the
    // pulse lines up with the second stage instead of lagging it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q   <= RST_VAL;
            s2_q   <= RST_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= d_i;
            s2_q   <= s1_q;
            rise_q <= s1_q & ~s2_q;
            fall_q <= ~s1_q & s2_q;
        end
    end

    assign q_o    = s2_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/fod_spi_slave.sv
// fod_spi_slave: SPI mode-0 target holding the FOD control register file.
//   clk_i, rst_i          : system clock (>= 8x SCLK), async active-high reset
//   sclk_i, cs_n_i, mosi_i: SPI pins, asynchronous to clk_i
//   miso_o                : read data, 0 while CS_N is high
//   wr_done_o, frame_err_o: one-cycle pulses at frame end
//   narst_o, fcw_fod_o and the remaining *_o: registered control fields
// Frame: bit15 W, bits14:10 ADDR, bits9:0 DATA, MSB first.
module fod_spi_slave
    import fod_spi_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            sclk_i,
    input  logic            cs_n_i,
    input  logic            mosi_i,
    output logic            miso_o,
    output logic            wr_done_o,
    output logic            frame_err_o,
    output logic            narst_o,
    output logic [WFCW-1:0] fcw_fod_o,
    output logic            pcali_en_o,
    output logic            freq_c_en_o,
    output logic            freq_c_mode_o,
    output logic            rt_en_o,
    output logic            dtccali_en_o,
    output logic            ofstcali_en_o,
    output logic            fcw_dn_en_o,
    output logic            sys_en_o,
    output logic            dsm_sync_nrst_en_o,
    output logic            nco_sync_nrst_en_o,
    output logic            freq_hop_o,
    output logic [4:0]      freq_c_ks_o,
    output logic [4:0]      pcali_ks_o,
    output logic [4:0]      kb_o,
    output logic [4:0]      kc_o,
    output logic [4:0]      kd_o,
    output logic [9:0]      phase_ctrl_o,
    output logic [9:0]      kdtcb_init_o,
    output logic [9:0]      kdtcc_init_o,
    output logic [9:0]      kdtcd_init0_o,
    output logic [9:0]      kdtcd_init1_o,
    output logic [2:0]      pcali_freqdown_o,
    output logic [1:0]      pseg_o,
    output logic [1:0]      caliorder_o,
    output logic [1:0]      fcw_dn_weight_o
);

    logic sclk_rise_s, sclk_fall_s, cs_rise_s, cs_fall_s, mosi_s;
    logic sclk_lvl_unused_s, cs_lvl_unused_s, mosi_rise_unused_s, mosi_fall_unused_s;

    spi_state_e      state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [15:0]     shift_q, shift_d;
    logic            ovr_q, ovr_d;
    logic [9:0]      tx_q, tx_d;
    logic            tx_vld_q, tx_vld_d;
    logic            miso_q, miso_d;
    logic            wr_done_q, wr_done_d;
    logic            frame_err_q, frame_err_d;
    logic [9:0]      regs_q [0:NREG-1];
    logic [9:0]      regs_d [0:NREG-1];
    logic [WFCW-1:0] fcw_q, fcw_d;

    logic [4:0] rd_addr_s;
    logic [9:0] rd_data_s;
    logic [4:0] wr_addr_s;
    logic [9:0] wr_data_s;

    fod_spi_sync #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(sclk_i),
        .q_o(sclk_lvl_unused_s), .rise_o(sclk_rise_s), .fall_o(sclk_fall_s)
    );

    // CS_N idles high, so its synchronizer resets high to avoid a false fall.
    fod_spi_sync #(.RST_VAL(1'b1)) u_sync_cs (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(cs_n_i),
        .q_o(cs_lvl_unused_s), .rise_o(cs_rise_s), .fall_o(cs_fall_s)
    );

    fod_spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(mosi_i),
        .q_o(mosi_s), .rise_o(mosi_rise_unused_s), .fall_o(mosi_fall_unused_s)
    );

    // On the 6th SCLK rise the address is the low 4 shifted bits plus the bit now arriving.
    assign wr_addr_s = shift_q[14:10];
    assign wr_data_s = shift_q[9:0];
    assign rd_addr_s = {shift_q[3:0], mosi_s};

    // Read-data mux; addresses past the map read 0.
    always_comb begin
        rd_data_s = 10'h000;
        if (rd_addr_s <= ADDR_KDTCD1) begin
            rd_data_s = regs_q[rd_addr_s[3:0]];
        end else begin
            rd_data_s = 10'h000;
        end
    end

    // Frame FSM, register commit and MISO shifter next-state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        ovr_d       = ovr_q;
        tx_d        = tx_q;
        tx_vld_d    = tx_vld_q;
        miso_d      = miso_q;
        wr_done_d   = 1'b0;
        frame_err_d = 1'b0;
        regs_d      = regs_q;
        fcw_d       = fcw_q;

        case (state_q)
            ST_IDLE: begin
                if (cs_fall_s) begin
                    cnt_d    = 5'd0;
                    ovr_d    = 1'b0;
                    tx_vld_d = 1'b0;
                    state_d  = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // CS_N rise wins over a coincident SCLK rise
                if (cs_rise_s) begin
                    frame_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end else if (sclk_rise_s) begin
                    shift_d = {shift_q[14:0], mosi_s};
                    cnt_d   = cnt_q + 5'd1;
                    // shift_q[4] holds W once five bits are in
                    if ((cnt_q == 5'd5) && !shift_q[4]) begin
                        tx_d     = rd_data_s;
                        tx_vld_d = 1'b1;
                    end else begin
                        tx_vld_d = tx_vld_q;
                    end
                    if (cnt_q == 5'd15) begin
                        state_d = ST_FULL;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_FULL: begin
                if (cs_rise_s) begin
                    state_d = ST_IDLE;
                    if (ovr_q) begin
                        frame_err_d = 1'b1;
                    end else begin
                        wr_done_d = 1'b1;
                        if (shift_q[15] && (wr_addr_s <= ADDR_KDTCD1)) begin
                            regs_d[wr_addr_s[3:0]] = wr_data_s & wr_mask(wr_addr_s);
                            // FCW commits atomically from staging on the top-slice write
                            if (wr_addr_s == ADDR_FCW2) begin
                                fcw_d = {wr_data_s[2:0], regs_q[4'(ADDR_FCW1)], regs_q[4'(ADDR_FCW0)]};
                            end else begin
                                fcw_d = fcw_q;
                            end
                        end else begin
                            fcw_d = fcw_q;
                        end
                    end
                end else if (sclk_rise_s) begin
                    ovr_d = 1'b1;
                end else begin
                    ovr_d = ovr_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // MISO: present tx MSB on each fall; refilling with bit 0 makes it hold bit 0.
        if (cs_rise_s) begin
            miso_d   = 1'b0;
            tx_vld_d = 1'b0;
        end else if (sclk_fall_s && tx_vld_q) begin
            miso_d = tx_q[9];
            tx_d   = {tx_q[8:0], tx_q[0]};
        end else begin
            miso_d = miso_q;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 5'd0;
            shift_q     <= 16'h0000;
            ovr_q       <= 1'b0;
            tx_q        <= 10'h000;
            tx_vld_q    <= 1'b0;
            miso_q      <= 1'b0;
            wr_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
            regs_q      <= REG_RST;
            fcw_q       <= RST_FCW;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            ovr_q       <= ovr_d;
            tx_q        <= tx_d;
            tx_vld_q    <= tx_vld_d;
            miso_q      <= miso_d;
            wr_done_q   <= wr_done_d;
            frame_err_q <= frame_err_d;
            regs_q      <= regs_d;
            fcw_q       <= fcw_d;
        end
    end

    assign miso_o      = miso_q;
    assign wr_done_o   = wr_done_q;
    assign frame_err_o = frame_err_q;
    assign fcw_fod_o   = fcw_q;

    assign pcali_en_o         = regs_q[4'(ADDR_CTRL)][0];
    assign freq_c_en_o        = regs_q[4'(ADDR_CTRL)][1];
    assign freq_c_mode_o      = regs_q[4'(ADDR_CTRL)][2];
    assign rt_en_o            = regs_q[4'(ADDR_CTRL)][3];
    assign dtccali_en_o       = regs_q[4'(ADDR_CTRL)][4];
    assign ofstcali_en_o      = regs_q[4'(ADDR_CTRL)][5];
    assign fcw_dn_en_o        = regs_q[4'(ADDR_CTRL)][6];
    assign sys_en_o           = regs_q[4'(ADDR_CTRL)][7];
    assign dsm_sync_nrst_en_o = regs_q[4'(ADDR_CTRL)][8];
    assign nco_sync_nrst_en_o = regs_q[4'(ADDR_CTRL)][9];

    assign freq_c_ks_o = regs_q[4'(ADDR_KS)][4:0];
    assign pcali_ks_o  = regs_q[4'(ADDR_KS)][9:5];

    assign phase_ctrl_o = regs_q[4'(ADDR_PHASE)];

    assign pcali_freqdown_o = regs_q[4'(ADDR_MISC)][2:0];
    assign pseg_o           = regs_q[4'(ADDR_MISC)][4:3];
    assign caliorder_o      = regs_q[4'(ADDR_MISC)][6:5];
    assign fcw_dn_weight_o  = regs_q[4'(ADDR_MISC)][8:7];
    assign freq_hop_o       = regs_q[4'(ADDR_MISC)][9];

    assign kb_o    = regs_q[4'(ADDR_KBC)][4:0];
    assign kc_o    = regs_q[4'(ADDR_KBC)][9:5];
    assign kd_o    = regs_q[4'(ADDR_KD)][4:0];
    assign narst_o = regs_q[4'(ADDR_KD)][5];

    assign kdtcb_init_o  = regs_q[4'(ADDR_KDTCB)];
    assign kdtcc_init_o  = regs_q[4'(ADDR_KDTCC)];
    assign kdtcd_init0_o = regs_q[4'(ADDR_KDTCD0)];
    assign kdtcd_init1_o = regs_q[4'(ADDR_KDTCD1)];

endmodule

// File: tb/tb_fod_spi_slave.sv
// Scoreboard bench for fod_spi_slave: each frame pushes its expected outcome,
// a monitor samples MISO/pulses/fields around CS_N and compares.
module tb_fod_spi_slave;

    localparam int H = 5;  // SCLK half period in CLK cycles

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk = 1'b0;
    logic        cs_n = 1'b1;
    logic        mosi = 1'b0;
    logic        miso, wr_done, frame_err, narst;
    logic [22:0] fcw;
    logic        pcali_en, freq_c_en, freq_c_mode, rt_en, dtccali_en, ofstcali_en;
    logic        fcw_dn_en, sys_en, dsm_en, nco_en, freq_hop;
    logic [4:0]  freq_c_ks, pcali_ks, kb, kc, kd;
    logic [9:0]  phase_ctrl, kdtcb, kdtcc, kdtcd0, kdtcd1;
    logic [2:0]  pcali_freqdown;
    logic [1:0]  pseg, caliorder, fcw_dn_weight;

    always #5 clk = ~clk;

    fod_spi_slave dut (
        .clk_i(clk), .rst_i(rst), .sclk_i(sclk), .cs_n_i(cs_n), .mosi_i(mosi),
        .miso_o(miso), .wr_done_o(wr_done), .frame_err_o(frame_err), .narst_o(narst),
        .fcw_fod_o(fcw), .pcali_en_o(pcali_en), .freq_c_en_o(freq_c_en),
        .freq_c_mode_o(freq_c_mode), .rt_en_o(rt_en), .dtccali_en_o(dtccali_en),
        .ofstcali_en_o(ofstcali_en), .fcw_dn_en_o(fcw_dn_en), .sys_en_o(sys_en),
        .dsm_sync_nrst_en_o(dsm_en), .nco_sync_nrst_en_o(nco_en), .freq_hop_o(freq_hop),
        .freq_c_ks_o(freq_c_ks), .pcali_ks_o(pcali_ks), .kb_o(kb), .kc_o(kc), .kd_o(kd),
        .phase_ctrl_o(phase_ctrl), .kdtcb_init_o(kdtcb), .kdtcc_init_o(kdtcc),
        .kdtcd_init0_o(kdtcd0), .kdtcd_init1_o(kdtcd1), .pcali_freqdown_o(pcali_freqdown),
        .pseg_o(pseg), .caliorder_o(caliorder), .fcw_dn_weight_o(fcw_dn_weight)
    );

    typedef struct {
        logic        chk_rd;
        logic [9:0]  rdata;
        int          wd_k;   // expected WR_DONE cycle after CS_N rise, 0 none, -1 don't care
        int          fe_k;   // expected FRAME_ERR cycle, 0 none
        int          fsel;   // field group sampled 3 cycles after CS_N rise, 0 none
        logic [31:0] fval;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   frame_no = 0;

    function automatic logic [15:0] mk(input logic w, input logic [4:0] a, input logic [9:0] d);
        return {w, a, d};
    endfunction

    function automatic exp_t mkexp(input logic chk_rd, input logic [9:0] rdata, input int wd_k,
                                   input int fe_k, input int fsel, input logic [31:0] fval);
        exp_t e;
        e.chk_rd = chk_rd; e.rdata = rdata; e.wd_k = wd_k;
        e.fe_k = fe_k; e.fsel = fsel; e.fval = fval;
        return e;
    endfunction

    // Field groups, each laid out like the register that owns it.
    function automatic logic [31:0] snap(input int sel);
        case (sel)
            1:  return {9'd0, fcw};
            2:  return {26'd0, narst, kd};
            3:  return {22'd0, phase_ctrl};
            4:  return {22'd0, nco_en, dsm_en, sys_en, fcw_dn_en, ofstcali_en, dtccali_en,
                        rt_en, freq_c_mode, freq_c_en, pcali_en};
            5:  return {22'd0, kc, kb};
            6:  return {22'd0, freq_hop, fcw_dn_weight, caliorder, pseg, pcali_freqdown};
            7:  return {22'd0, pcali_ks, freq_c_ks};
            8:  return {22'd0, kdtcb};
            9:  return {22'd0, kdtcc};
            10: return {22'd0, kdtcd0};
            11: return {22'd0, kdtcd1};
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s frame %0d: got 0x%0h expected 0x%0h", name, frame_no, act, expv);
        end
    endtask

    // Drive one frame; rst_at >= 0 asserts RST after that many bits instead of closing normally.
    task automatic xfer(input logic [15:0] fr, input int nbits, input int rst_at, input exp_t e);
        logic [15:0] sh;
        logic        aborted;
        q.push_back(e);
        sh = fr;
        aborted = 1'b0;
        @(negedge clk); cs_n = 1'b0;
        repeat (H) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                aborted = 1'b1;
                break;
            end
            mosi = sh[15];
            sh = sh << 1;
            repeat (H) @(negedge clk); sclk = 1'b1;
            repeat (H) @(negedge clk); sclk = 1'b0;
        end
        if (aborted) begin
            rst = 1'b1;
            @(negedge clk); cs_n = 1'b1; mosi = 1'b0;
            repeat (10) @(negedge clk); rst = 1'b0;
            repeat (6) @(negedge clk);
        end else begin
            repeat (H) @(negedge clk); cs_n = 1'b1; mosi = 1'b0;
            repeat (12) @(negedge clk);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [9:0] d, input int fsel, input logic [31:0] fv);
        xfer(mk(1'b1, a, d), 16, -1, mkexp(1'b0, 10'd0, 3, 0, fsel, fv));
    endtask

    task automatic rd(input logic [4:0] a, input logic [9:0] d, input int fsel, input logic [31:0] fv);
        xfer(mk(1'b0, a, 10'd0), 16, -1, mkexp(1'b1, d, -1, 0, fsel, fv));
    endtask

    // Monitor: host-side MISO capture on SCLK rises 7..16, then an 8-cycle window after CS_N rises.
    int          m_nr, m_wd_seen, m_wd_cnt, m_fe_seen, m_fe_cnt;
    logic [9:0]  m_rx;
    logic [31:0] m_fs;
    exp_t        m_e;
    initial begin : monitor
        forever begin
            @(negedge cs_n);
            m_nr = 0; m_rx = 10'd0;
            while (cs_n == 1'b0) begin
                @(posedge sclk or posedge cs_n);
                if (cs_n == 1'b0) begin
                    m_nr++;
                    if (m_nr >= 7 && m_nr <= 16) m_rx = {m_rx[8:0], miso};
                end
            end
            frame_no++;
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_frame frame %0d: got a frame expected none", frame_no);
                continue;
            end
            m_e = q.pop_front();
            m_wd_seen = 0; m_wd_cnt = 0; m_fe_seen = 0; m_fe_cnt = 0; m_fs = 32'd0;
            for (int k = 1; k <= 8; k++) begin
                @(negedge clk);
                if (wr_done === 1'b1) begin
                    m_wd_cnt++;
                    if (m_wd_seen == 0) m_wd_seen = k;
                end
                if (frame_err === 1'b1) begin
                    m_fe_cnt++;
                    if (m_fe_seen == 0) m_fe_seen = k;
                end
                if (k == 3) m_fs = snap(m_e.fsel);
            end
            if (m_e.wd_k >= 0) begin
                chk("wr_done_cycle", m_wd_seen, m_e.wd_k);
                chk("wr_done_count", m_wd_cnt, (m_e.wd_k != 0) ? 1 : 0);
            end
            chk("frame_err_cycle", m_fe_seen, m_e.fe_k);
            chk("frame_err_count", m_fe_cnt, (m_e.fe_k != 0) ? 1 : 0);
            if (m_e.chk_rd) chk("miso_rdata", {22'd0, m_rx}, {22'd0, m_e.rdata});
            if (m_e.fsel != 0) chk($sformatf("field_grp%0d", m_e.fsel), m_fs, m_e.fval);
            chk("miso_idle", {31'd0, miso}, 32'd0);
        end
    end

    logic [9:0] rst_tab [0:12] = '{10'h28F, 10'h210, 10'h000, 10'h309, 10'h100, 10'h000,
                                   10'h178, 10'h3A0, 10'h01D, 10'h2B6, 10'h15B, 10'h064, 10'h064};
    int         grp_tab [0:12] = '{1, 1, 1, 4, 7, 3, 6, 5, 2, 8, 9, 10, 11};

    initial begin : stim
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // reset values through MISO, plus the field group behind each address
        for (int i = 0; i < 13; i++) begin
            rd(5'(i), rst_tab[i], grp_tab[i],
               (grp_tab[i] == 1) ? 32'h0008428F : {22'd0, rst_tab[i]});
        end

        // staged FCW commit
        wr(5'h00, 10'h123, 1, 32'h0008428F);
        wr(5'h01, 10'h045, 1, 32'h0008428F);
        wr(5'h02, 10'h001, 1, 32'h00111523);
        rd(5'h00, 10'h123, 1, 32'h00111523);
        rd(5'h02, 10'h001, 0, 32'd0);

        // NARST / KD, then unused bits reading back 0
        wr(5'h08, 10'h03D, 2, 32'h0000003D);
        rd(5'h08, 10'h03D, 0, 32'd0);
        wr(5'h08, 10'h3FF, 2, 32'h0000003F);
        rd(5'h08, 10'h03F, 0, 32'd0);

        // aborted after 9 bits, then a 17-bit overrun frame
        xfer(mk(1'b1, 5'h05, 10'h3FF), 9, -1, mkexp(1'b0, 10'd0, 0, 3, 3, 32'd0));
        xfer(mk(1'b1, 5'h05, 10'h3FF), 17, -1, mkexp(1'b0, 10'd0, 0, 3, 3, 32'd0));
        rd(5'h05, 10'h000, 3, 32'd0);

        // out-of-range address
        wr(5'h1F, 10'h3FF, 1, 32'h00111523);
        rd(5'h1F, 10'h000, 2, 32'h0000003F);

        // RST mid-frame after enabling SYS_EN only
        wr(5'h03, 10'h080, 4, 32'h00000080);
        xfer(mk(1'b1, 5'h05, 10'h2AA), 16, 8, mkexp(1'b0, 10'd0, 0, 0, 4, 32'h00000309));
        rd(5'h00, 10'h28F, 1, 32'h0008428F);
        wr(5'h05, 10'h155, 3, 32'h00000155);
        rd(5'h05, 10'h155, 2, 32'h0000001D);

        for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
